// File: rtl/quick_spi.sv
// quick_spi: SPI master running a whole write or read (command then data) per start request.
// Optional: define QUICK_SPI_INCOMING_CLEAR_EN to zero incoming_data when a read starts.
`timescale 1ns/1ps
module quick_spi #(
   parameter int   INCOMING_DATA_WIDTH = 8,
   parameter int   OUTGOING_DATA_WIDTH = 16,
   parameter logic CPOL                = 1'b0,
   parameter logic CPHA                = 1'b0,
   parameter int   NUMBER_OF_SLAVES    = 2,
   parameter int   BYTES_ORDER         = 0,
   parameter int   BITS_ORDER          = 0
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           enable,
   input  logic                           start_transaction,
   input  logic [1:0]                     slave,
   input  logic                           operation,
   output logic                           end_of_transaction,
   output logic [INCOMING_DATA_WIDTH-1:0] incoming_data,
   input  logic [OUTGOING_DATA_WIDTH-1:0] outgoing_data,
   output logic                           mosi,
   input  logic                           miso,
   output logic                           sclk,
   output logic [NUMBER_OF_SLAVES-1:0]    ss_n
);

   localparam int IW = INCOMING_DATA_WIDTH;
   localparam int OW = OUTGOING_DATA_WIDTH;
   localparam int TW = IW + OW;
   localparam int CW = $clog2(2*TW+1);
   localparam logic [CW-1:0] LAST_WR = CW'(2*OW-1);
   localparam logic [CW-1:0] LAST_RD = CW'(2*TW-1);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_SETUP    = 2'd1;
   localparam logic [1:0] S_TRANSFER = 2'd2;
   localparam logic [1:0] S_DONE     = 2'd3;

   // Bit k of the result is the k-th bit on the wire. The byte/bit swap is its own
   // inverse, so the same mapping also turns received wire order back into data.
   function automatic logic [OW-1:0] wire_out(input logic [OW-1:0] d);
      logic [OW-1:0] w;
      int sb, si;
      w = '0;
      for (int k = 0; k < OW; k++) begin
         sb = (BYTES_ORDER != 0) ? (OW/8 - 1 - k/8) : (k/8);
         si = (BITS_ORDER  != 0) ? (7 - k%8)        : (k%8);
         w[k] = d[sb*8 + si];
      end
      return w;
   endfunction

   function automatic logic [IW-1:0] wire_in(input logic [IW-1:0] d);
      logic [IW-1:0] w;
      int sb, si;
      w = '0;
      for (int k = 0; k < IW; k++) begin
         sb = (BYTES_ORDER != 0) ? (IW/8 - 1 - k/8) : (k/8);
         si = (BITS_ORDER  != 0) ? (7 - k%8)        : (k%8);
         w[k] = d[sb*8 + si];
      end
      return w;
   endfunction

   logic [1:0]                  state_q, state_d;
   logic [CW-1:0]               edge_q, edge_d;
   logic [TW-1:0]               tx_q, tx_d;
   logic [IW-1:0]               rx_q, rx_d;
   logic                        op_q, op_d;
   logic                        sclk_q, sclk_d;
   logic                        mosi_q, mosi_d;
   logic [NUMBER_OF_SLAVES-1:0] ss_n_q, ss_n_d;
   logic                        eot_q, eot_d;
   logic [IW-1:0]               inc_q, inc_d;

   logic [TW-1:0] tx_load;
   logic [IW-1:0] rx_nxt;
   logic          lead, shift_edge, sample_edge, data_phase;

   // Upper IW bits stay zero so mosi is 0 throughout the read data phase.
   assign tx_load     = {{IW{1'b0}}, wire_out(outgoing_data)};
   assign lead        = (edge_q[0] == 1'b0);
   assign shift_edge  = CPHA ? lead : !lead;
   assign sample_edge = !shift_edge;
   assign data_phase  = ((edge_q >> 1) >= CW'(OW));

   always_comb begin
      rx_nxt = rx_q;
      if (!op_q && data_phase && sample_edge)
         rx_nxt = {miso, rx_q[IW-1:1]};
   end

   always_comb begin
      state_d = state_q;
      edge_d  = edge_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      op_d    = op_q;
      sclk_d  = sclk_q;
      mosi_d  = mosi_q;
      ss_n_d  = ss_n_q;
      eot_d   = 1'b0;
      inc_d   = inc_q;
      case (state_q)
         S_IDLE: begin
            sclk_d = CPOL;
            if (start_transaction) begin
               op_d   = operation;
               edge_d = '0;
               rx_d   = '0;
               for (int i = 0; i < NUMBER_OF_SLAVES; i++)
                  ss_n_d[i] = (int'(slave) != i);
               if (CPHA == 1'b0) begin
                  mosi_d = tx_load[0];
                  tx_d   = tx_load >> 1;
               end else begin
                  mosi_d = 1'b0;
                  tx_d   = tx_load;
               end
`ifdef QUICK_SPI_INCOMING_CLEAR_EN
               if (!operation) inc_d = '0;
`endif
               state_d = S_SETUP;
            end
         end
         S_SETUP: state_d = S_TRANSFER;
         S_TRANSFER: begin
            sclk_d = ~sclk_q;
            edge_d = edge_q + 1'b1;
            rx_d   = rx_nxt;
            if (shift_edge) begin
               mosi_d = tx_q[0];
               tx_d   = tx_q >> 1;
            end
            if (edge_q == (op_q ? LAST_WR : LAST_RD)) begin
               state_d = S_DONE;
               ss_n_d  = '1;
               mosi_d  = 1'b0;
               eot_d   = 1'b1;
               if (!op_q) inc_d = wire_in(rx_nxt);
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Disable wins over everything, including a completing transfer.
      if (!enable) begin
         state_d = S_IDLE;
         ss_n_d  = '1;
         sclk_d  = CPOL;
         mosi_d  = 1'b0;
         eot_d   = 1'b0;
         inc_d   = inc_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         edge_q  <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         op_q    <= 1'b0;
         sclk_q  <= CPOL;
         mosi_q  <= 1'b0;
         ss_n_q  <= '1;
         eot_q   <= 1'b0;
         inc_q   <= '0;
      end else begin
         state_q <= state_d;
         edge_q  <= edge_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         op_q    <= op_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
         ss_n_q  <= ss_n_d;
         eot_q   <= eot_d;
         inc_q   <= inc_d;
      end
   end

   assign sclk               = sclk_q;
   assign mosi               = mosi_q;
   assign ss_n               = ss_n_q;
   assign end_of_transaction = eot_q;
   assign incoming_data      = inc_q;

endmodule

// File: tb/tb_quick_spi.sv
// Directed bench for quick_spi: default, byte/bit-swapped and CPOL=1/CPHA=1 instances.
`timescale 1ns/1ps
module tb_quick_spi;

   logic        clk = 1'b0;
   logic        reset_n, enable, operation, miso;
   logic [2:0]  start_v;
   logic [1:0]  slave;
   logic [15:0] outgoing;

   logic [2:0]       eot_w, mosi_w, sclk_w;
   logic [2:0][7:0]  inc_w;
   logic [2:0][1:0]  ss_w;

   quick_spi u_dut0 (
      .clk(clk), .reset_n(reset_n), .enable(enable), .start_transaction(start_v[0]),
      .slave(slave), .operation(operation), .end_of_transaction(eot_w[0]),
      .incoming_data(inc_w[0]), .outgoing_data(outgoing), .mosi(mosi_w[0]),
      .miso(miso), .sclk(sclk_w[0]), .ss_n(ss_w[0]));

   quick_spi #(.BYTES_ORDER(1), .BITS_ORDER(1)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .enable(enable), .start_transaction(start_v[1]),
      .slave(slave), .operation(operation), .end_of_transaction(eot_w[1]),
      .incoming_data(inc_w[1]), .outgoing_data(outgoing), .mosi(mosi_w[1]),
      .miso(miso), .sclk(sclk_w[1]), .ss_n(ss_w[1]));

   quick_spi #(.CPOL(1'b1), .CPHA(1'b1)) u_dut2 (
      .clk(clk), .reset_n(reset_n), .enable(enable), .start_transaction(start_v[2]),
      .slave(slave), .operation(operation), .end_of_transaction(eot_w[2]),
      .incoming_data(inc_w[2]), .outgoing_data(outgoing), .mosi(mosi_w[2]),
      .miso(miso), .sclk(sclk_w[2]), .ss_n(ss_w[2]));

   always #5 clk = ~clk;

   logic [1:0] sel;
   logic       m_sclk, m_mosi, m_eot;
   logic [1:0] m_ss;
   logic [7:0] m_inc;
   always_comb begin
      m_sclk = sclk_w[sel];
      m_mosi = mosi_w[sel];
      m_eot  = eot_w[sel];
      m_ss   = ss_w[sel];
      m_inc  = inc_w[sel];
   end

   int pass_cnt = 0;
   int chk_cnt  = 0;

   bit seq_le[16] = '{0,1,0,1,0,1,1,0, 0,1,0,1,1,0,1,0};
   bit seq_be[16] = '{0,1,0,1,1,0,1,0, 0,1,1,0,1,0,1,0};

   logic [47:0] mon_bits;
   int          mon_rise, mon_edge, mon_eot, mon_ssbad, mon_chg;
   logic [7:0]  mon_inc;
   logic [1:0]  mon_ab_ss;
   logic        mon_ab_sclk;
   logic [1:0]  exp_ss;
   logic [7:0]  slave_byte;

   // Starts one transaction on instance dsel and watches it; the slave model
   // drives slave_byte LSB-first on miso after each falling sclk of the data phase.
   task automatic run_txn(input int dsel, input int abort_at, input int max_cyc);
      logic prev_s, prev_m;
      int tail, ab;
      sel = 2'(dsel);
      mon_bits = '0; mon_rise = 0; mon_edge = 0; mon_eot = 0; mon_ssbad = 0; mon_chg = 0;
      mon_inc = '0; mon_ab_ss = '0; mon_ab_sclk = 1'b0;
      tail = -1; ab = 0;
      #1;
      prev_s = m_sclk; prev_m = m_mosi;
      start_v[dsel] = 1'b1;
      for (int c = 0; c < max_cyc; c++) begin
         @(negedge clk);
         if (c == 0) start_v = '0;
         if (ab == 1) begin mon_ab_ss = m_ss; mon_ab_sclk = m_sclk; ab = 2; end
         if (m_sclk !== prev_s) begin
            mon_edge++;
            if (m_sclk) begin
               if (mon_rise < 48) mon_bits[mon_rise] = m_mosi;
               if (m_mosi !== prev_m) mon_chg++;
               mon_rise++;
            end else if (mon_rise >= 16 && mon_rise < 24) begin
               miso = slave_byte[mon_rise-16];
            end
         end
         if (m_ss !== 2'b11 && m_ss !== exp_ss) mon_ssbad++;
         if (m_eot) begin
            mon_eot++;
            mon_inc = m_inc;
            if (m_ss !== 2'b11) mon_ssbad++;
            if (tail < 0) tail = 3;
         end
         if (abort_at > 0 && ab == 0 && mon_edge == abort_at) begin enable = 1'b0; ab = 1; end
         prev_s = m_sclk; prev_m = m_mosi;
         if (tail == 0) break;
         if (tail > 0) tail--;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; enable = 1'b0; start_v = '0; slave = 2'd0; operation = 1'b0;
      outgoing = '0; miso = 1'b0; sel = 2'd0; exp_ss = 2'b11; slave_byte = '0;
      #12;
      chk_cnt++; if (sclk_w[0] !== 1'b0) $display("FAIL rst_sclk0: got %b exp 0", sclk_w[0]); else pass_cnt++;
      chk_cnt++; if (sclk_w[2] !== 1'b1) $display("FAIL rst_sclk2: got %b exp 1", sclk_w[2]); else pass_cnt++;
      chk_cnt++; if (ss_w[0] !== 2'b11) $display("FAIL rst_ss: got %b exp 11", ss_w[0]); else pass_cnt++;
      chk_cnt++; if (mosi_w[0] !== 1'b0) $display("FAIL rst_mosi: got %b exp 0", mosi_w[0]); else pass_cnt++;
      chk_cnt++; if (eot_w[0] !== 1'b0) $display("FAIL rst_eot: got %b exp 0", eot_w[0]); else pass_cnt++;
      chk_cnt++; if (inc_w[0] !== 8'h00) $display("FAIL rst_inc: got %h exp 00", inc_w[0]); else pass_cnt++;
      @(negedge clk); reset_n = 1'b1; enable = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic check_write(input string nm, input bit le);
      logic [15:0] exp;
      for (int i = 0; i < 16; i++) exp[i] = le ? seq_le[i] : seq_be[i];
      chk_cnt++; if (mon_edge !== 32) $display("FAIL %s_edges: got %0d exp 32", nm, mon_edge); else pass_cnt++;
      chk_cnt++; if (mon_eot !== 1) $display("FAIL %s_eot: got %0d exp 1", nm, mon_eot); else pass_cnt++;
      chk_cnt++; if (mon_bits[15:0] !== exp) $display("FAIL %s_mosi: got %h exp %h", nm, mon_bits[15:0], exp); else pass_cnt++;
      chk_cnt++; if (mon_ssbad !== 0) $display("FAIL %s_ss: got %0d bad exp 0", nm, mon_ssbad); else pass_cnt++;
   endtask

   task automatic test_write();
      slave = 2'd1; operation = 1'b1; outgoing = 16'h5A6A; exp_ss = 2'b01;
      run_txn(0, 0, 200);
      check_write("wr", 1'b1);
   endtask

   task automatic test_read();
      logic [15:0] exp;
      for (int i = 0; i < 16; i++) exp[i] = seq_le[i];
      slave = 2'd1; operation = 1'b0; outgoing = 16'h5A6A; exp_ss = 2'b01; slave_byte = 8'hA5;
      run_txn(0, 0, 200);
      chk_cnt++; if (mon_edge !== 48) $display("FAIL rd_edges: got %0d exp 48", mon_edge); else pass_cnt++;
      chk_cnt++; if (mon_eot !== 1) $display("FAIL rd_eot: got %0d exp 1", mon_eot); else pass_cnt++;
      chk_cnt++; if (mon_inc !== 8'hA5) $display("FAIL rd_inc: got %h exp a5", mon_inc); else pass_cnt++;
      chk_cnt++; if (mon_bits[15:0] !== exp) $display("FAIL rd_cmd: got %h exp %h", mon_bits[15:0], exp); else pass_cnt++;
      chk_cnt++; if (mon_bits[23:16] !== 8'h00) $display("FAIL rd_mosi0: got %h exp 00", mon_bits[23:16]); else pass_cnt++;
   endtask

   task automatic test_write_keeps_incoming();
      operation = 1'b1; outgoing = 16'h1234;
      run_txn(0, 0, 200);
      chk_cnt++; if (inc_w[0] !== 8'hA5) $display("FAIL wr_keep_inc: got %h exp a5", inc_w[0]); else pass_cnt++;
   endtask

   task automatic test_enable_abort();
      slave = 2'd1; operation = 1'b1; outgoing = 16'h5A6A; exp_ss = 2'b01;
      run_txn(0, 10, 30);
      chk_cnt++; if (mon_ab_ss !== 2'b11) $display("FAIL ab_ss: got %b exp 11", mon_ab_ss); else pass_cnt++;
      chk_cnt++; if (mon_ab_sclk !== 1'b0) $display("FAIL ab_sclk: got %b exp 0", mon_ab_sclk); else pass_cnt++;
      chk_cnt++; if (mon_eot !== 0) $display("FAIL ab_eot: got %0d exp 0", mon_eot); else pass_cnt++;
      chk_cnt++; if (inc_w[0] !== 8'hA5) $display("FAIL ab_inc: got %h exp a5", inc_w[0]); else pass_cnt++;
      enable = 1'b1;
      repeat (2) @(negedge clk);
      run_txn(0, 0, 200);
      check_write("ab_rerun", 1'b1);
   endtask

   task automatic test_back_to_back();
      int ne, ntx, last_eot;
      int edges[3];
      int gap[2];
      logic prev_s;
      logic [1:0] prev_ss;
      sel = 2'd0; miso = 1'b1; slave = 2'd1; operation = 1'b1; exp_ss = 2'b01;
      ne = 0; ntx = 0; last_eot = 0;
      edges = '{-1, -1, -1}; gap = '{-1, -1};
      #1;
      prev_s = m_sclk; prev_ss = m_ss;
      start_v[0] = 1'b1;
      for (int c = 0; c < 400 && ntx < 3; c++) begin
         @(negedge clk);
         if (m_sclk !== prev_s) ne++;
         if (prev_ss === 2'b11 && m_ss !== 2'b11 && ntx > 0) gap[ntx-1] = c - last_eot;
         if (m_eot) begin
            edges[ntx] = ne; ne = 0; last_eot = c; ntx++;
            operation = ~operation;
            if (ntx == 3) start_v[0] = 1'b0;
         end
         prev_s = m_sclk; prev_ss = m_ss;
      end
      start_v = '0;
      repeat (4) @(negedge clk);
      chk_cnt++; if (ntx !== 3) $display("FAIL b2b_count: got %0d exp 3", ntx); else pass_cnt++;
      chk_cnt++; if (edges[0] !== 32) $display("FAIL b2b_e0: got %0d exp 32", edges[0]); else pass_cnt++;
      chk_cnt++; if (edges[1] !== 48) $display("FAIL b2b_e1: got %0d exp 48", edges[1]); else pass_cnt++;
      chk_cnt++; if (edges[2] !== 32) $display("FAIL b2b_e2: got %0d exp 32", edges[2]); else pass_cnt++;
      chk_cnt++; if (gap[0] !== 2) $display("FAIL b2b_gap0: got %0d exp 2", gap[0]); else pass_cnt++;
      chk_cnt++; if (gap[1] !== 2) $display("FAIL b2b_gap1: got %0d exp 2", gap[1]); else pass_cnt++;
      chk_cnt++; if (inc_w[0] !== 8'hFF) $display("FAIL b2b_inc: got %h exp ff", inc_w[0]); else pass_cnt++;
   endtask

   task automatic test_order_big_msb();
      slave = 2'd1; operation = 1'b1; outgoing = 16'h5A6A; exp_ss = 2'b01;
      run_txn(1, 0, 200);
      check_write("be", 1'b0);
   endtask

   task automatic test_cpol_cpha();
      slave = 2'd0; operation = 1'b1; outgoing = 16'h5A6A; exp_ss = 2'b10;
      chk_cnt++; if (sclk_w[2] !== 1'b1) $display("FAIL m3_idle: got %b exp 1", sclk_w[2]); else pass_cnt++;
      run_txn(2, 0, 200);
      check_write("m3", 1'b1);
      chk_cnt++; if (mon_chg !== 0) $display("FAIL m3_mosi_on_rise: got %0d exp 0", mon_chg); else pass_cnt++;
      chk_cnt++; if (sclk_w[2] !== 1'b1) $display("FAIL m3_idle_after: got %b exp 1", sclk_w[2]); else pass_cnt++;
   endtask

   task automatic test_async_reset();
      slave = 2'd1; operation = 1'b1; outgoing = 16'h5A6A;
      start_v[0] = 1'b1;
      @(negedge clk); start_v = '0;
      repeat (8) @(negedge clk);
      chk_cnt++; if (ss_w[0] !== 2'b01) $display("FAIL ar_active: got %b exp 01", ss_w[0]); else pass_cnt++;
      #2 reset_n = 1'b0;
      #1;
      chk_cnt++; if (ss_w[0] !== 2'b11) $display("FAIL ar_ss: got %b exp 11", ss_w[0]); else pass_cnt++;
      chk_cnt++; if (sclk_w[0] !== 1'b0) $display("FAIL ar_sclk: got %b exp 0", sclk_w[0]); else pass_cnt++;
      chk_cnt++; if (inc_w[0] !== 8'h00) $display("FAIL ar_inc: got %h exp 00", inc_w[0]); else pass_cnt++;
      @(negedge clk); reset_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_write_keeps_incoming();
      test_enable_abort();
      test_back_to_back();
      test_order_big_msb();
      test_cpol_cpha();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/quick_spi.md
Name: quick_spi

Overview:
Parameterised SPI master that runs complete write or read transactions to one of several slaves on a single start request. Sits between a local controller (register/command logic) and the external SPI pins. Configurable byte order, bit order and SPI mode. Signals completion with a one-cycle end_of_transaction pulse.

Parameters:
INCOMING_DATA_WIDTH, 8, bits captured from miso in a read (multiple of 8)
OUTGOING_DATA_WIDTH, 16, bits shifted out on mosi (multiple of 8)
CPOL, 0, sclk idle level
CPHA, 0, 0 = sample on leading edge, shift on trailing edge; 1 = shift on leading edge, sample on trailing edge
NUMBER_OF_SLAVES, 2, width of ss_n (1..4)
BYTES_ORDER, 0, 0 = little endian (byte [7:0] first on the wire), 1 = big endian (top byte first)
BITS_ORDER, 0, 0 = LSB first within each byte, 1 = MSB first

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  block enable; low aborts and holds idle
start_transaction  in  1  level request, sampled in IDLE
slave  in  2  index of target slave
operation  in  1  0 = read, 1 = write
end_of_transaction  out  1  one-cycle completion pulse
incoming_data  out  INCOMING_DATA_WIDTH  last read result
outgoing_data  in  OUTGOING_DATA_WIDTH  data/command to send
mosi  out  1  serial out
miso  in  1  serial in
sclk  out  1  SPI clock, clk/2 during transfer
ss_n  out  NUMBER_OF_SLAVES  active-low slave selects

Behaviour:
- Reset (async, reset_n=0): state IDLE, sclk=CPOL, ss_n all 1, mosi=0, end_of_transaction=0, incoming_data=0.
- States: IDLE, SETUP, TRANSFER, DONE.
- IDLE: if enable && start_transaction, latch operation, slave and outgoing_data (reordered per BYTES_ORDER/BITS_ORDER into a shift register), drive ss_n[slave]=0 (others 1; slave >= NUMBER_OF_SLAVES selects none but transaction still runs), present first bit on mosi (CPHA=0), go SETUP.
- SETUP: one clk cycle, sclk=CPOL, then TRANSFER.
- TRANSFER: sclk toggles every clk. Bit count N = OUTGOING_DATA_WIDTH for write; OUTGOING_DATA_WIDTH + INCOMING_DATA_WIDTH for read (command phase, then data phase with mosi held 0). Total 2N sclk edges (32 write, 48 read with defaults). Sample edge: capture miso only during read data phase. Shift edge: present next bit. After the 2N-th edge, sclk is back at CPOL; go DONE.
- Received bits assembled by same BYTES_ORDER/BITS_ORDER rule: first received byte goes to incoming_data[7:0] when little endian, to the top byte when big endian.
- DONE: ss_n all 1, end_of_transaction=1 for exactly this cycle. incoming_data updated in this cycle on reads, unchanged on writes. Go IDLE.
- start_transaction held high: a new transaction starts from IDLE one cycle after the pulse. operation/slave/outgoing_data are sampled at that start cycle; changes mid-transaction are ignored.
- enable low in any state: next clk returns to IDLE, ss_n deasserted, sclk=CPOL, no end_of_transaction pulse, incoming_data unchanged.
- Async reset mid-transaction: immediate return to reset values.

Optional Feature:
QUICK_SPI_INCOMING_CLEAR_EN
- Defined: incoming_data clears to 0 at the start of every read transaction (IDLE->SETUP).
- Not defined: incoming_data holds the previous read result until the new DONE.

Test Plan:
- Reset, then enable=1, start=1, slave=1, operation=1, outgoing_data=0x5A6A, BYTES_ORDER=0, BITS_ORDER=0 -> ss_n=2'b01 during transfer; mosi at rising sclk: 0,1,0,1,0,1,1,0,0,1,0,1,1,0,1,0; 32 sclk edges; one end_of_transaction pulse.
- Read, same settings; slave drives 0xA5 LSB-first in the data phase -> after 48 edges, incoming_data=0xA5 on the end_of_transaction cycle.
- start held high, operation toggled on each end_of_transaction -> alternating write/read transactions, each separated by one IDLE cycle.
- BYTES_ORDER=1, BITS_ORDER=1, write 0x5A6A -> mosi: 0,1,0,1,1,0,1,0,0,1,1,0,1,0,1,0.
- Drop enable mid-transfer (edge 10) -> ss_n=all 1 next cycle, sclk idle, no end_of_transaction; next start runs normally.
- CPOL=1, CPHA=1 write -> sclk idles high; mosi changes on falling edges; sampling occurs on rising edges.
